// File: rtl/bytes_to_bits_pkg.sv
// Shared types and constants for the byte-to-bit serializer.
package bytes_to_bits_pkg;

    localparam int unsigned BITS_PER_BYTE = 8;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

endpackage

// File: rtl/bytes_to_bits_stream.sv
// Serializes a stream of bytes into LSB-first bits with frame-relative indices.
// Optional feature: define BYTES_TO_BITS_SKID_EN to add a one-byte hold register
// so consecutive bytes stream with no bubble (8 cycles/byte instead of 9).
module bytes_to_bits_stream
    import bytes_to_bits_pkg::*;
#(
    parameter int unsigned BYTE_LENGTH = 32,
    parameter int unsigned BIT_LENGTH  = BYTE_LENGTH * 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [7:0]                    in_byte,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_bit,
    output logic [$clog2(BIT_LENGTH)-1:0] out_idx,
    output logic                          out_last,
    output logic                          busy
);

    localparam int unsigned IDX_W    = $clog2(BIT_LENGTH);
    localparam int unsigned BCNT_W   = (BYTE_LENGTH > 1) ? $clog2(BYTE_LENGTH) : 1;
    localparam int unsigned BITCNT_W = $clog2(BITS_PER_BYTE);

    state_t              r_state;
    logic [7:0]          r_shift;
    logic [BITCNT_W-1:0] r_bit_cnt;
    logic [BCNT_W-1:0]   r_byte_cnt;
    logic                r_ready_en;
`ifdef BYTES_TO_BITS_SKID_EN
    logic [7:0]          r_hold;
    logic                r_hold_valid;
`endif

    logic             w_active;
    logic             w_in_xfer;
    logic             w_out_xfer;
    logic             w_bit7;
    logic             w_last;
    logic [IDX_W-1:0] w_idx;

    assign w_active   = (r_state == SHIFT);
    assign w_bit7     = (r_bit_cnt == BITCNT_W'(BITS_PER_BYTE - 1));
    assign w_last     = w_bit7 && (r_byte_cnt == BCNT_W'(BYTE_LENGTH - 1));
    // byte_cnt*8 + bit_cnt; the concatenation width equals IDX_W except when BYTE_LENGTH is 1
    assign w_idx      = IDX_W'({r_byte_cnt, r_bit_cnt});

`ifdef BYTES_TO_BITS_SKID_EN
    assign in_ready   = r_ready_en && (!w_active || !r_hold_valid);
`else
    assign in_ready   = r_ready_en && !w_active;
`endif

    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = w_active && out_ready;

    assign out_valid  = w_active;
    assign out_bit    = w_active && r_shift[0];
    assign out_idx    = w_active ? w_idx : '0;
    assign out_last   = w_active && w_last;
    assign busy       = w_active;

    // FSM, shift register, counters and optional hold register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_byte_cnt   <= '0;
            r_ready_en   <= 1'b0;
`ifdef BYTES_TO_BITS_SKID_EN
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
`endif
        end else begin
            r_ready_en <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (w_in_xfer) begin
                        r_shift   <= in_byte;
                        r_bit_cnt <= '0;
                        r_state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (w_out_xfer) begin
                        if (w_bit7) begin
                            r_bit_cnt  <= '0;
                            r_byte_cnt <= w_last ? '0 : r_byte_cnt + 1'b1;
`ifdef BYTES_TO_BITS_SKID_EN
                            if (r_hold_valid) begin
                                r_shift      <= r_hold;
                                r_hold_valid <= 1'b0;
                            end else if (w_in_xfer) begin
                                // Hold empty but a byte arrives now: feed it straight in
                                r_shift <= in_byte;
                            end else begin
                                r_shift <= '0;
                                r_state <= IDLE;
                            end
`else
                            r_shift <= '0;
                            r_state <= IDLE;
`endif
                        end else begin
                            r_shift   <= r_shift >> 1;
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
`ifdef BYTES_TO_BITS_SKID_EN
                    // Park an accepted byte unless it went directly into the shifter
                    if (w_in_xfer && !(w_out_xfer && w_bit7 && !r_hold_valid)) begin
                        r_hold       <= in_byte;
                        r_hold_valid <= 1'b1;
                    end
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bytes_to_bits_stream.sv
// Scoreboard bench for bytes_to_bits_stream (BYTE_LENGTH = 2).
module tb_bytes_to_bits_stream;

    localparam int unsigned BL   = 2;
    localparam int unsigned IDXW = $clog2(BL * 8);
`ifdef BYTES_TO_BITS_SKID_EN
    localparam int EXP_SPAN = 256;
`else
    localparam int EXP_SPAN = 288;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [7:0]      in_byte = 8'h00;
    logic            out_valid;
    logic            out_ready;
    logic            out_bit;
    logic [IDXW-1:0] out_idx;
    logic            out_last;
    logic            busy;

    bytes_to_bits_stream #(
        .BYTE_LENGTH(BL)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_byte  (in_byte),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_bit  (out_bit),
        .out_idx  (out_idx),
        .out_last (out_last),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic            b;
        logic [IDXW-1:0] idx;
        logic            last;
        logic            mark;
    } exp_t;

    exp_t sb[$];
    int   marks[$];
    int   checks = 0;
    int   errors = 0;
    int   n_xfer = 0;
    int   cyc    = 0;
    int   pos    = 0;
    bit   rand_ready = 1'b0;

    bit exp30 [16] = '{0, 1, 0, 1, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0};
    bit exp31 [8]  = '{0, 0, 0, 0, 1, 1, 1, 1};
    bit exp33 [8]  = '{0, 0, 0, 0, 0, 0, 0, 1};

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic push_exp(input bit b, input int idx, input bit last, input bit mark);
        exp_t e;
        e.b    = b;
        e.idx  = IDXW'(idx);
        e.last = last;
        e.mark = mark;
        sb.push_back(e);
    endtask

    // Reference BytesToBits for a byte at the bench's current frame position
    task automatic push_model(input logic [7:0] b, input bit mark);
        for (int j = 0; j < 8; j++) begin
            push_exp(b[j], pos * 8 + j, (pos == BL - 1) && (j == 7), mark && (j == 0));
        end
        pos = (pos + 1) % BL;
    endtask

    // Called at a negedge; returns at the negedge after the transfer with in_valid still high.
    // While stalled, in_byte carries a value differing from the real byte.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        in_valid = 1'b1;
        while (!in_ready) begin
            in_byte = b ^ 8'($urandom_range(1, 255));
            @(negedge clk);
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: in_ready stayed 0 for byte %0h", b);
                return;
            end
        end
        in_byte = b;
        @(negedge clk);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        in_valid = 1'b0;
        while ((sb.size() != 0) && (n < 3000)) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        @(negedge clk);
        check({name, "_drained"}, sb.size(), 0);
        check({name, "_idle"}, {31'd0, busy}, 0);
    endtask

    // Monitor: drives out_ready, pops the scoreboard on each output transfer, checks stalls
    initial begin : monitor
        bit              stall;
        bit              s_bit;
        bit              s_last;
        logic [IDXW-1:0] s_idx;
        exp_t            e;
        stall     = 1'b0;
        s_bit     = 1'b0;
        s_last    = 1'b0;
        s_idx     = '0;
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            cyc++;
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!rst_n) begin
                stall = 1'b0;
                continue;
            end
            if (stall) begin
                checks++;
                if (!(out_valid === 1'b1 && out_bit === s_bit && out_idx === s_idx &&
                      out_last === s_last)) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%b b=%b i=%0d l=%b required v=1 b=%b i=%0d l=%b",
                             out_valid, out_bit, out_idx, out_last, s_bit, s_idx, s_last);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_bit: got b=%b i=%0d with empty scoreboard",
                             out_bit, out_idx);
                end else begin
                    e = sb.pop_front();
                    if (out_bit !== e.b || out_idx !== e.idx || out_last !== e.last) begin
                        errors++;
                        $display("FAIL bit_out: got b=%b i=%0d l=%b required b=%b i=%0d l=%b",
                                 out_bit, out_idx, out_last, e.b, e.idx, e.last);
                    end
                    if (e.mark) marks.push_back(cyc);
                end
                n_xfer++;
            end
            stall  = out_valid && !out_ready;
            s_bit  = out_bit;
            s_idx  = out_idx;
            s_last = out_last;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int base;
        int n;
        #1 rst_n = 1'b0;
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_out_idx", int'(out_idx), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 check("rst_in_ready", {31'd0, in_ready}, 1);
        @(negedge clk);

        // Two-byte frame 0xAA, 0x01
        for (int i = 0; i < 16; i++) push_exp(exp30[i], i, i == 15, 1'b0);
        send_byte(8'hAA);
        send_byte(8'h01);
        drain("frame_aa01");

        // Random stalls with 0xF0, then 0x69 continuing the frame
        rand_ready = 1'b1;
        for (int i = 0; i < 8; i++) push_exp(exp31[i], i, 1'b0, 1'b0);
        pos = 1;
        send_byte(8'hF0);
        push_model(8'h69, 1'b0);
        send_byte(8'h69);
        drain("stall_f0");
        rand_ready = 1'b0;

        // Two frames back-to-back
        push_model(8'h5A, 1'b0);
        send_byte(8'h5A);
        push_model(8'hC3, 1'b0);
        send_byte(8'hC3);
        push_model(8'h0F, 1'b0);
        send_byte(8'h0F);
        push_model(8'h81, 1'b0);
        send_byte(8'h81);
        drain("two_frames");

        // Reset after 5 bits of a frame
        base = n_xfer;
        push_model(8'h3C, 1'b0);
        send_byte(8'h3C);
        in_valid = 1'b0;
        n = 0;
        while ((n_xfer < base + 5) && (n < 100)) begin
            @(posedge clk);
            n++;
        end
        check("reset_reach_5bits", (n_xfer >= base + 5) ? 1 : 0, 1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 0);
        check("midrst_out_last", {31'd0, out_last}, 0);
        check("midrst_out_idx", int'(out_idx), 0);
        check("midrst_out_bit", {31'd0, out_bit}, 0);
        check("midrst_busy", {31'd0, busy}, 0);
        sb.delete();
        pos = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 check("midrst_in_ready", {31'd0, in_ready}, 1);
        @(negedge clk);
        for (int i = 0; i < 8; i++) push_exp(exp33[i], i, 1'b0, 1'b0);
        pos = 1;
        send_byte(8'h80);
        drain("after_reset_80");

        // Sustained stream: span between bit 0 of byte 0 and bit 0 of byte 32
        marks.delete();
        for (int k = 0; k < 33; k++) begin
            logic [7:0] b;
            b = 8'((k * 37 + 11) & 8'hFF);
            push_model(b, (k == 0) || (k == 32));
            send_byte(b);
        end
        drain("stream");
        check("stream_marks", marks.size(), 2);
        if (marks.size() == 2) check("stream_span_cycles", marks[1] - marks[0], EXP_SPAN);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bytes_to_bits_stream.md
BYTES_TO_BITS_STREAM -- requirements
Module: bytes_to_bits_stream

Interface
REQ-001 The block SHALL have parameter BYTE_LENGTH, default 32, meaning bytes per frame (must be at least 1).
REQ-002 The block SHALL have parameter BIT_LENGTH, default BYTE_LENGTH*8, meaning bits per frame (derived; not overridden).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: in_byte holds a valid byte.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block can accept a byte.
REQ-007 The block SHALL have port in_byte, input, 8 bits: the next frame byte B[j].
REQ-008 The block SHALL have port out_valid, output, 1 bit: out_bit is valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the bit.
REQ-010 The block SHALL have port out_bit, output, 1 bit: frame bit b[i] = (B[i/8] >> (i mod 8)) & 1.
REQ-011 The block SHALL have port out_idx, output, $clog2(BIT_LENGTH) bits: index i of out_bit within the frame.
REQ-012 The block SHALL have port out_last, output, 1 bit: high when i = BIT_LENGTH-1.
REQ-013 The block SHALL have port busy, output, 1 bit: the FSM is not IDLE.

Function
REQ-014 Input transfer SHALL occur on a clk edge where in_valid && in_ready; output transfer SHALL occur where out_valid && out_ready.
REQ-015 The FSM SHALL have two states. IDLE: accepting a byte loads the shift register and moves to SHIFT. SHIFT: emit 8 bits, LSB first.
REQ-016 Latency: a byte accepted at edge N SHALL present its bit 0 with out_valid=1 from cycle N+1.
REQ-017 In SHIFT, each output transfer SHALL shift right by 1 and increment the bit-in-byte counter (0..7).
REQ-018 The transfer of bit 7 SHALL return the FSM to IDLE, unless a next byte is available under REQ-026.
REQ-019 While out_valid && !out_ready, out_bit, out_idx and out_last SHALL hold stable, and out_valid SHALL not drop.
REQ-020 out_idx SHALL equal byte_cnt*8 + bit_cnt, where byte_cnt counts accepted bytes modulo BYTE_LENGTH.
REQ-021 On transfer of the bit with out_last=1, byte_cnt SHALL wrap to 0 so the next byte starts a new frame at idx 0; no idle cycle is inserted beyond normal state behaviour.
REQ-022 in_valid while in_ready=0 SHALL be ignored; in_byte SHALL be sampled only on an input transfer.
REQ-023 out_valid SHALL be 0 in IDLE, and out_bit/out_idx/out_last SHALL then be don't-care (driven 0).

Reset
REQ-024 While rst_n=0 (asynchronous assert, synchronous deassert): state=IDLE, all counters, shift register and hold register = 0; out_valid=0, out_last=0, out_idx=0, out_bit=0, busy=0, and in_ready=1 from the first edge after release.
REQ-025 Reset asserted mid-frame SHALL discard the partial frame; the first byte after reset SHALL be frame byte 0.

Configuration
REQ-026 Macro BYTES_TO_BITS_SKID_EN defined: a one-byte hold register SHALL be present and in_ready = (state==IDLE) || !hold_valid. At a bit-7 transfer with hold_valid=1, the hold byte SHALL load into the shift register and SHIFT continues with no bubble (8 cycles/byte sustained). An input transfer on the same edge as that load SHALL refill the hold register.
REQ-027 Macro undefined: no hold register SHALL exist and in_ready = (state==IDLE), giving 9 cycles/byte sustained.

Structure
REQ-028 A package bytes_to_bits_pkg SHALL hold the state enum type (IDLE, SHIFT) and the constant BITS_PER_BYTE=8.
REQ-029 No sub-module SHALL exist; the optional hold register is inline logic.

Verification
REQ-030 The bench SHALL check: BYTE_LENGTH=2, bytes 0xAA,0x01, out_ready=1 -> bits 0,1,0,1,0,1,0,1,1,0,0,0,0,0,0,0; idx 0..15; out_last only at idx 15.
REQ-031 The bench SHALL check: out_ready toggled randomly with 0xF0 -> each bit held stable while stalled; sequence 0,0,0,0,1,1,1,1 unchanged.
REQ-032 The bench SHALL check: 2 frames back-to-back -> second frame idx restarts at 0 after out_last; data matches the reference BytesToBits.
REQ-033 The bench SHALL check: rst_n pulsed low after 5 bits of frame -> outputs per REQ-024 immediately; next byte 0x80 emitted at idx 0..7 as 0,0,0,0,0,0,0,1.
REQ-034 The bench SHALL check: 32 bytes streamed, in_valid and out_ready held high -> 256 bits in 256 cycles with SKID_EN; 288 cycles without.
REQ-035 The bench SHALL check: in_valid asserted while in_ready=0 with a changing in_byte -> the ignored value never appears on out_bit.
